// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - pipeline hazard, branch flush and post-reset clear controller
module hazard_flush_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             Branch_store,
    input  logic             Zero_store,
    input  logic             Is_Greater_store,
    input  logic [3:0]       funct_in_store,
    output logic             PCSrc,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             busy_init,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RUN     = 2'd1,
        S_FLUSHED = 2'd2
    } state_t;

    localparam logic [3:0]       INIT_LOAD = 4'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic take;
    logic lu;
    logic cond;
    logic unused_funct_hi;

    // funct bit 3 carries no branch information; only funct3 selects the condition
    assign unused_funct_hi = funct_in_store[3];

    // Branch resolution in MEM from the comparator flags and funct3
    always_comb begin
        cond = 1'b0;
        case (funct_in_store[2:0])
            3'b000:  cond = Zero_store;
            3'b001:  cond = !Zero_store;
            3'b100:  cond = !Zero_store && !Is_Greater_store;
            3'b101:  cond = Zero_store || Is_Greater_store;
            default: cond = 1'b0;
        endcase
        take = Branch_store && cond;
    end

    // Load-use: ID reads a register that the load in EX has not yet produced (x0 never hazards)
    always_comb begin
        lu = IDEX_MemRead && (IDEX_rd != 5'd0) &&
             ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
    end

    // Next state and Mealy control outputs
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        PCSrc       = 1'b0;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        busy_init   = 1'b0;
        case (state_q)
            S_INIT: begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IFID_Flush  = 1'b1;
                IDEX_Flush  = 1'b1;
                EXMEM_Flush = 1'b1;
                busy_init   = 1'b1;
                if (init_cnt_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 4'd1;
                end
            end
            S_RUN: begin
                if (take) begin
                    PCSrc       = 1'b1;
                    IFID_Flush  = 1'b1;
                    IDEX_Flush  = 1'b1;
                    EXMEM_Flush = 1'b1;
                    state_d     = S_FLUSHED;
                end else if (lu) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                end
            end
            S_FLUSHED: begin
                // wrong-path bubbles occupy ID/EX/MEM, so hazards seen here are not real
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Saturating event counters, only advanced by RUN-state decisions
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (state_q == S_RUN) begin
            if (take) begin
                if (flush_q != CNT_MAX) begin
                    flush_d = flush_q + CNT_ONE;
                end
            end else if (lu) begin
                if (stall_q != CNT_MAX) begin
                    stall_d = stall_q + CNT_ONE;
                end
            end
        end
    end

    // State, init counter and event counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= INIT_LOAD;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - directed and random checks of hazard_flush_ctrl against a cycle model
module tb_hazard_flush_ctrl;

    localparam int INIT_CYCLES = 3;
    localparam int CNT_W       = 4;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_rd, IFID_rs1, IFID_rs2;
    logic             Branch_store, Zero_store, Is_Greater_store;
    logic [3:0]       funct_in_store;
    logic             PCSrc, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, busy_init;
    logic [CNT_W-1:0] stall_count, flush_count;

    hazard_flush_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .Branch_store(Branch_store), .Zero_store(Zero_store),
        .Is_Greater_store(Is_Greater_store), .funct_in_store(funct_in_store),
        .PCSrc(PCSrc), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
        .busy_init(busy_init), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: cycles of INIT still to run, whether the last cycle was a branch flush, event tallies
    int init_left;
    bit in_flushed;
    int m_stall, m_flush;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_take(input bit br, z, g, input logic [3:0] f);
        int f3 = int'(f) % 8;
        if (!br) return 0;
        if (f3 == 0) return z;
        if (f3 == 1) return !z;
        if (f3 == 4) return !z && !g;
        if (f3 == 5) return z || g;
        return 0;
    endfunction

    function automatic bit model_lu(input bit mr, input int rd, rs1, rs2);
        return mr && rd != 0 && (rd == rs1 || rd == rs2);
    endfunction

    // One clock cycle: drive inputs, compare combinational outputs and counters, advance the model
    task automatic step(input bit rst, mr, input int rd, rs1, rs2,
                        input bit br, z, g, input int f, input string tag);
        bit t, l;
        int e_pcsrc, e_pcw, e_ifw, e_iff, e_idf, e_exf, e_busy;
        reset = rst; IDEX_MemRead = mr;
        IDEX_rd = 5'(rd); IFID_rs1 = 5'(rs1); IFID_rs2 = 5'(rs2);
        Branch_store = br; Zero_store = z; Is_Greater_store = g;
        funct_in_store = 4'(f);
        #3;
        t = model_take(br, z, g, 4'(f));
        l = model_lu(mr, rd, rs1, rs2);
        e_pcsrc = 0; e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_busy = 0;
        if (init_left > 0) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_exf = 1; e_busy = 1;
        end else if (!in_flushed && t) begin
            e_pcsrc = 1; e_iff = 1; e_idf = 1; e_exf = 1;
        end else if (!in_flushed && l) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
        end
        chk({tag, ".out"},
            int'({PCSrc, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, busy_init}),
            (e_pcsrc << 6) | (e_pcw << 5) | (e_ifw << 4) | (e_iff << 3) | (e_idf << 2) | (e_exf << 1) | e_busy);
        chk({tag, ".stall"}, int'(stall_count), m_stall);
        chk({tag, ".flush"}, int'(flush_count), m_flush);
        @(posedge clk);
        if (rst) begin
            init_left = INIT_CYCLES; in_flushed = 0; m_stall = 0; m_flush = 0;
        end else if (init_left > 0) begin
            init_left--;
        end else if (in_flushed) begin
            in_flushed = 0;
        end else if (t) begin
            in_flushed = 1;
            if (m_flush < CNT_SAT) m_flush++;
        end else if (l) begin
            if (m_stall < CNT_SAT) m_stall++;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        bit rb;
        init_left = INIT_CYCLES; in_flushed = 0; m_stall = 0; m_flush = 0;
        reset = 1'b1; IDEX_MemRead = 0; IDEX_rd = 0; IFID_rs1 = 0; IFID_rs2 = 0;
        Branch_store = 0; Zero_store = 0; Is_Greater_store = 0; funct_in_store = 0;
        @(posedge clk); #1;

        // reset and INIT length
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        chk("rst.busy", int'(busy_init), 1);
        chk("rst.exflush", int'(EXMEM_Flush), 1);
        for (int i = 0; i < INIT_CYCLES; i++) idle("init");
        chk("init.done_busy", int'(busy_init), 0);
        chk("init.pcwrite", int'(PCWrite), 1);

        // load-use on rs2, then x0 destination
        step(0, 1, 5, 1, 5, 0, 0, 0, 0, "lu5");
        idle("lu5.after");
        chk("lu5.count", int'(stall_count), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "lu0");
        chk("lu0.count", int'(stall_count), 1);

        // taken beq, FLUSHED ignores a load-use, then untaken bne
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, "beq");
        step(0, 1, 7, 7, 0, 0, 0, 0, 0, "flushed_lu");
        chk("beq.count", int'(flush_count), 1);
        chk("flushed_lu.stall", int'(stall_count), 1);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, "bne_nt");
        chk("bne_nt.count", int'(flush_count), 1);

        // branch and hazard together: branch wins
        step(0, 1, 9, 9, 3, 1, 0, 1, 5, "bge_lu");
        idle("bge_lu.after");
        chk("bge_lu.flush", int'(flush_count), 2);
        chk("bge_lu.stall", int'(stall_count), 1);

        // stall counter saturation
        for (int i = 0; i < 20; i++) step(0, 1, 12, 12, 12, 0, 0, 0, 0, "sat");
        chk("sat.count", int'(stall_count), CNT_SAT);

        // reset while in FLUSHED
        step(0, 0, 0, 0, 0, 1, 0, 0, 4, "blt");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_flushed");
        chk("rst_flushed.busy", int'(busy_init), 1);
        chk("rst_flushed.iff", int'(IFID_Flush), 1);
        chk("rst_flushed.stall", int'(stall_count), 0);
        chk("rst_flushed.flush", int'(flush_count), 0);

        // random traffic with a small register range to make hazards frequent
        for (int i = 0; i < 600; i++) begin
            rb = ($urandom_range(0, 59) == 0);
            step(rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It drives the `Flush` inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC and IF/ID write enables. It detects load-use hazards, where the instruction in ID needs a value still being loaded by the instruction in EX, and resolves taken branches evaluated in MEM. It also runs a post-reset pipeline-clear sequence and keeps saturating stall and flush event counters.

## Interface
Parameters:
- INIT_CYCLES, 3: cycles after reset deasserts during which all pipeline registers are held flushed (range 1..15).
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- IDEX_MemRead  input  1  MemRead of the instruction in EX.
- IDEX_rd  input  5  destination register of the instruction in EX.
- IFID_rs1, IFID_rs2  input  5 each  source registers of the instruction in ID.
- Branch_store, Zero_store, Is_Greater_store  input  1 each  MEM-stage outputs of EX/MEM.
- funct_in_store  input  4  MEM-stage funct; bits [2:0] are funct3.
- PCSrc  output  1  select branch target (PCplusimm_store) as next PC.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID register load enable.
- IFID_Flush, IDEX_Flush, EXMEM_Flush  output  1 each  zero the respective pipeline register on the next edge.
- busy_init  output  1  high while in INIT.
- stall_count  output  CNT_W  number of load-use stall cycles, saturating.
- flush_count  output  CNT_W  number of taken-branch flushes, saturating.

## Operation
- Branch decision, combinational: `take = Branch_store & cond`, where cond is selected by funct3 as follows:
  - 000 beq: Zero_store.
  - 001 bne: !Zero_store.
  - 100 blt: !Zero_store & !Is_Greater_store.
  - 101 bge: Zero_store | Is_Greater_store.
  - Any other funct3: cond = 0.
- Load-use detection, combinational: `lu = IDEX_MemRead & (IDEX_rd != 0) & (IDEX_rd == IFID_rs1 | IDEX_rd == IFID_rs2)`.
- FSM states: INIT, RUN, FLUSHED.
  - INIT:
    - Outputs: PCWrite=0, IFID_Write=0, all three Flush=1, PCSrc=0, busy_init=1.
    - A 4-bit down-counter loads INIT_CYCLES−1 while reset is high and decrements each cycle reset is low.
    - Go to RUN on the cycle the counter reads 0 with reset low.
  - RUN:
    - If take: PCSrc=1, PCWrite=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, IFID_Write=1, then go to FLUSHED.
    - Else if lu: PCWrite=0, IFID_Write=0, IDEX_Flush=1 (bubble into EX), other Flush=0; stay in RUN.
    - Else: PCWrite=IFID_Write=1, all Flush=0, PCSrc=0.
  - FLUSHED (one cycle, wrong-path bubbles in ID/EX/MEM):
    - lu and take are ignored: PCWrite=IFID_Write=1, all Flush=0, PCSrc=0.
    - Always go to RUN next.
- Priority: reset > INIT > take > lu. When take and lu are both true in RUN, the branch wins, stall_count does not increment and flush_count does.
- Counters:
  - stall_count increments on each RUN cycle with lu & !take.
  - flush_count increments on each RUN cycle with take.
  - Both saturate at 2^CNT_W−1; no wrap.
  - Both clear to 0 only on reset, and hold during INIT.

## Timing
- All control outputs are combinational (Mealy) from the current state and inputs, so the pipeline registers act on the same rising edge.
- State and counters update on the rising edge of clk.
- Reset value, state = INIT: PCWrite=0, IFID_Write=0, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, PCSrc=0, busy_init=1, stall_count=0, flush_count=0.
- With reset deasserted at edge E0, INIT outputs hold for INIT_CYCLES cycles and RUN outputs first appear in cycle INIT_CYCLES after E0.
- Load-use penalty is exactly 1 cycle: lu is false on the next cycle because IDEX_MemRead is 0 in the bubble.
- Branch penalty is 3 flushed instructions and the FSM occupies FLUSHED for exactly 1 cycle.
- Reset asserted in any state returns to INIT on the next edge, with counters cleared on that same edge.

## Test plan
- Reset release with INIT_CYCLES=3: all Flush=1 and PCWrite=0 for exactly 3 cycles after reset falls, busy_init then drops to 0, counters read 0.
- Load-use, IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5: one cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1, then normal flow; stall_count=1. Repeat with IDEX_rd=0: no stall.
- Taken beq (Branch_store=1, funct3=000, Zero_store=1): PCSrc=1 and all three Flush=1 for one cycle, FSM in FLUSHED next cycle, flush_count=1. Repeat with bne and Zero_store=1: no flush.
- Branch plus hazard, take=1 and lu=1 in the same cycle: flush outputs asserted, PCWrite=1, stall_count unchanged, flush_count+1. A lu condition in the FLUSHED cycle produces no stall.
- Saturation with CNT_W=4: 20 forced load-use stalls leave stall_count=15.
- Mid-operation reset, asserted in FLUSHED: next cycle in INIT, all Flush=1, both counters 0.
